// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the 8x8 async FIFO and its read-side adapters.
package fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;

    // Ceil(log2(n)); n <= 1 yields 0.
    function automatic int clogb2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin end
        return r;
    endfunction

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = clogb2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words out of the FIFO read adapter.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_skid2.sv
// Generic 2-entry valid/ready buffer; head entry drives out_data directly.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SKID_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      ent0, ent1;
    logic [SKID_CNT_W-1:0] cnt;
    logic                  pop;

    assign out_valid = (cnt != '0);
    assign out_data  = ent0;
    assign count     = cnt;
    assign pop       = out_valid & pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == '0) ent0 <= push_data;
                    else           ent1 <= push_data;
                    cnt <= cnt + SKID_CNT_W'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - SKID_CNT_W'(1);
                end
                // Simultaneous push/pop: head advances, new word lands behind it.
                2'b11: begin
                    if (cnt == SKID_CNT_W'(2)) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        ent0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt == SKID_CNT_W'(SKID_DEPTH)));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= SKID_CNT_W'(SKID_DEPTH));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a 2-entry buffer, and counts delivered words.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic              rdclk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [WIDTH-1:0]  fifo_q,
    output logic              fifo_rd,
    input  logic              enable,
    fifo_rd_stream_if.master  m_if,
    output logic [CNT_W-1:0]  rd_cnt
);

    logic                  pending;
    logic                  fire;
    logic                  buf_valid;
    logic [WIDTH-1:0]      buf_data;
    logic [SKID_CNT_W-1:0] buf_cnt;
    logic [2:0]            occ_nxt;

    fifo_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (rdclk),
        .rst_n     (rst_n),
        .push      (pending),
        .push_data (fifo_q),
        .pop_ready (m_if.m_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .count     (buf_cnt)
    );

    assign m_if.m_valid = buf_valid;
    assign m_if.m_data  = buf_data;
    assign fire         = buf_valid & m_if.m_ready;

    // Occupancy after this edge; a new read only if it leaves room for the
    // word that will arrive one cycle later.
    assign occ_nxt = 3'(buf_cnt) + 3'(pending) - 3'(fire);
    assign fifo_rd = rst_n & enable & ~fifo_empty & (occ_nxt <= 3'd1);

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            pending <= fifo_rd & ~fifo_empty;
            if (fire) rd_cnt <= rd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: behavioural FIFO read port in front of the adapter,
// expected words queued at write time and checked by a negedge monitor.
module tb_fifo_rd_stream;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          rdclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          m_ready = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          fifo_rd, fifo_empty;
    logic [W-1:0]  fifo_q;
    logic [CW-1:0] rd_cnt;
    logic          m_valid;
    logic [W-1:0]  m_data;

    always #5 rdclk = ~rdclk;

    fifo_rd_stream_if #(.WIDTH(W)) s_if ();
    assign s_if.m_ready = m_ready;
    assign m_valid      = s_if.m_valid;
    assign m_data       = s_if.m_data;

    fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .rdclk      (rdclk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .enable     (enable),
        .m_if       (s_if.master),
        .rd_cnt     (rd_cnt)
    );

    // Behavioural 8-deep FIFO read port with registered q
    logic [W-1:0] mem [8];
    logic [2:0]   wp, rp;
    logic [3:0]   fcnt;
    logic         f_pop, f_push, fire;
    assign fifo_empty = (fcnt == 4'd0);
    assign f_pop      = fifo_rd & ~fifo_empty;
    assign f_push     = wr_en & (fcnt != 4'd8);
    assign fire       = m_valid & m_ready;

    always @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; fcnt <= '0; fifo_q <= '0;
        end else begin
            if (f_push) begin mem[wp] <= wr_data; wp <= wp + 3'd1; end
            if (f_pop)  begin fifo_q <= mem[rp];  rp <= rp + 3'd1; end
            fcnt <= fcnt + 4'(f_push) - 4'(f_pop);
        end
    end

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;
    int inflight, pop_cnt, fire_cnt, t_rd, t_vld, t_first, t_last;
    logic hold;
    logic [W-1:0] hold_data, exp_w;

    always @(posedge rdclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge rdclk); #2;
    endtask

    task automatic clear_stats();
        pop_cnt = 0; fire_cnt = 0; t_rd = -1; t_vld = -1; t_first = -1; t_last = -1;
    endtask

    // Monitor: scoreboard pops, counter tracking and invariants
    always @(negedge rdclk) begin
        if (!rst_n) begin
            exp_cnt = '0; inflight = 0; hold = 1'b0;
        end else begin
            chk("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
            chk("inflight_le_2", 32'(inflight <= 2), 32'd1);
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(hold_data));
            end
            if (f_pop && t_rd < 0) t_rd = cyc;
            if (m_valid && t_vld < 0) t_vld = cyc;
            if (f_pop) begin inflight++; pop_cnt++; end
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("stream_data", 32'(m_data), 32'(exp_w));
                end
                chk("rd_cnt_track", 32'(rd_cnt), 32'(exp_cnt));
                exp_cnt = exp_cnt + CW'(1);
                inflight--; fire_cnt++;
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
            end
            hold = m_valid & ~m_ready;
            hold_data = m_data;
        end
    end

    task automatic wr(input logic [W-1:0] d);
        int g = 0;
        while (fcnt >= 4'd8 && g < 200) begin tick(); g++; end
        wr_en = 1'b1; wr_data = d; exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || m_valid) && g < 100) begin tick(); g++; end
        chk(name, 32'(g < 100), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        exp_q.delete();
        wr_en = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic alt_done;

    initial begin
        clear_stats();
        tick();
        do_reset();

        // Idle with empty FIFO
        for (int i = 0; i < 20; i++) begin
            @(negedge rdclk);
            chk("idle_state", {29'd0, fifo_rd, m_valid, 1'b0} | 32'(rd_cnt), 32'd0);
        end
        tick();

        // Streaming with m_ready held high
        clear_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'h11 + 8'(i));
        wait_drain("stream_drain");
        chk("stream_latency", 32'(t_vld - t_rd), 32'd2);
        chk("stream_no_gap", 32'(t_last - t_vld), 32'd7);
        chk("stream_rd_cnt", 32'(rd_cnt), 32'd8);

        // Back-pressure: only two words leave the FIFO
        clear_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h21 + 8'(i));
        repeat (4) tick();
        chk("bp_pops", 32'(pop_cnt), 32'd2);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_head", 32'(m_data), 32'h21);
        clear_stats();
        m_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_fires", 32'(fire_cnt), 32'd8);
        chk("bp_no_gap", 32'(t_last - t_first), 32'd7);

        // Alternating ready with irregular writes
        alt_done = 1'b0;
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    wr(8'h60 + 8'(i));
                    repeat ($urandom_range(0, 2)) tick();
                end
                wait_drain("alt_drain");
                alt_done = 1'b1;
            end
            begin
                while (!alt_done) begin m_ready = ~m_ready; tick(); end
            end
        join
        m_ready = 1'b0;
        tick();

        // Enable dropped while a word is pending
        wr(8'h40);
        tick();
        enable = 1'b0;
        clear_stats();
        wr(8'h41);
        wr(8'h42);
        m_ready = 1'b1;
        repeat (5) tick();
        chk("en_no_reads", 32'(pop_cnt), 32'd0);
        chk("en_pending_out", 32'(fire_cnt), 32'd1);
        chk("en_left", 32'(exp_q.size()), 32'd2);
        enable = 1'b1;
        wait_drain("en_drain");

        // Reset mid-stream with a full buffer and words still queued
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i));
        repeat (2) tick();
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) wr(8'hA0 + 8'(i));
        wait_drain("post_rst_drain");
        chk("post_rst_cnt", 32'(rd_cnt), 32'd3);

        // Counter wrap at 2^CW
        do_reset();
        for (int i = 0; i < 17; i++) wr(8'h50 + 8'(i));
        wait_drain("wrap_drain");
        chk("wrap_cnt", 32'(rd_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end

endmodule
